// File: rtl/hamming74_codec_arbiter.sv
// Two-port round-robin front end sharing one Hamming(7,4) encoder/decoder pair; 1-cycle latency, one registered response.
// Backpressure: req_ready drops while the held response is not being drained; rsp_* hold stable until rsp_ready.
// Optional saturating decode-error counter is built only when HAMMING74_ARB_ERR_CNT_EN is defined.

module hamming74_enc (
  input  logic [3:0] data,
  output logic [6:0] code
);
  // Data sits on codeword bits 6,5,4,2; parity on bits 3,1,0.
  assign code = {data[3], data[2], data[1],
                 data[1] ^ data[2] ^ data[3],
                 data[0],
                 data[0] ^ data[2] ^ data[3],
                 data[0] ^ data[1] ^ data[3]};
endmodule

module hamming74_dec (
  input  logic [6:0] code,
  output logic [3:0] info,
  output logic [2:0] syndrome,
  output logic       err
);
  logic       s_a, s_b, s_c;
  logic [2:0] pos;
  logic [6:0] fix;
  logic [6:0] fixed;

  assign s_a = code[0] ^ code[2] ^ code[4] ^ code[6];
  assign s_b = code[1] ^ code[2] ^ code[5] ^ code[6];
  assign s_c = code[3] ^ code[4] ^ code[5] ^ code[6];
  assign pos = {s_c, s_b, s_a};

  // Only data positions are flipped back; parity-bit errors leave the data untouched.
  always_comb begin
    fix = '0;
    case (pos)
      3'd3:    fix = 7'b0000100;
      3'd5:    fix = 7'b0010000;
      3'd6:    fix = 7'b0100000;
      3'd7:    fix = 7'b1000000;
      default: fix = '0;
    endcase
  end

  assign fixed    = code ^ fix;
  assign info     = {fixed[6], fixed[5], fixed[4], fixed[2]};
  assign syndrome = {s_a, s_b, s_c};
  assign err      = |pos;
endmodule

module hamming74_codec_arbiter #(
  parameter int CNT_W   = 8,
  parameter int RR_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op,
  input  logic [13:0]      req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [6:0]       rsp_data,
  output logic             rsp_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state_q, state_d;
  logic       ptr_q;
  logic       grant;
  logic       load;
  logic       xfer;
  logic [6:0] sel_data;
  logic       sel_op;
  logic [6:0] enc_code;
  logic [3:0] dec_info;
  logic [2:0] dec_syn;
  logic       dec_err;
  logic [6:0] res_data;
  logic       res_err;
  logic       id_q;
  logic [6:0] data_q;
  logic       err_q;

  assign load = (state_q == EMPTY) | (rsp_ready & (state_q == FULL));

  // Grant is derived from req_valid and the pointer only, never from req_ready.
  always_comb begin
    grant = ptr_q;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ptr_q;
    endcase
  end

  assign req_ready = load ? (req_valid & (2'b01 << grant)) : 2'b00;
  assign xfer      = |req_ready;

  assign sel_data = grant ? req_data[13:7] : req_data[6:0];
  assign sel_op   = req_op[grant];

  hamming74_enc u_enc (
    .data (sel_data[3:0]),
    .code (enc_code)
  );

  hamming74_dec u_dec (
    .code     (sel_data),
    .info     (dec_info),
    .syndrome (dec_syn),
    .err      (dec_err)
  );

  assign res_data = sel_op ? enc_code : {dec_syn, dec_info};
  assign res_err  = ~sel_op & dec_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (rsp_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= 1'(RR_INIT);
      id_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (xfer) begin
      ptr_q  <= ~grant;
      id_q   <= grant;
      data_q <= res_data;
      err_q  <= res_err;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

`ifdef HAMMING74_ARB_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= '0;
    end else if (xfer && res_err && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming74_codec_arbiter.sv
// Directed bench for hamming74_codec_arbiter: encode/decode, fairness, backpressure, reset and error counter.
module tb_hamming74_codec_arbiter;
  localparam int CNT_W = 3;
`ifdef HAMMING74_ARB_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op;
  logic [13:0]      req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [6:0]       rsp_data;
  logic             rsp_err;
  logic             err_clr;
  logic [CNT_W-1:0] err_count;

  int checks;
  int errors;

  hamming74_codec_arbiter #(.CNT_W(CNT_W), .RR_INIT(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .err_clr   (err_clr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [6:0] dat, input logic err);
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},  32'(rsp_id),    32'(id));
    check({tag, "_dat"}, 32'(rsp_data),  32'(dat));
    check({tag, "_err"}, 32'(rsp_err),   32'(err));
  endtask

  // Fairness vectors: req0 encodes 1 -> 0x07, req1 encodes 2 -> 0x19.
  logic [1:0] fair_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic       fair_id  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [6:0] fair_dat [4] = '{7'h07, 7'h19, 7'h07, 7'h19};

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req_valid = 2'b00;
    req_op    = 2'b00;
    req_data  = '0;
    rsp_ready = 1'b1;
    err_clr   = 1'b0;

    @(negedge clk);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_id",  32'(rsp_id),    32'd0);
    check("rst_dat", 32'(rsp_data),  32'd0);
    check("rst_err", 32'(rsp_err),   32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Encode 4'hB on requester 0
    req_valid = 2'b01; req_op = 2'b01; req_data = {7'h00, 7'h0B};
    #1 check("enc_rdy", 32'(req_ready), 32'b01);
    tick();
    check_rsp("enc", 1'b0, 7'h55, 1'b0);

    // Clean decode on requester 1
    req_valid = 2'b10; req_op = 2'b00; req_data = {7'h55, 7'h00};
    #1 check("dec_rdy", 32'(req_ready), 32'b10);
    tick();
    check_rsp("dec", 1'b1, 7'h0B, 1'b0);

    // Data bit 2 flipped: corrected, syndrome 110
    req_data = {7'h51, 7'h00};
    tick();
    check_rsp("cor", 1'b1, 7'h6B, 1'b1);
    check("cor_cnt", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);

    // Parity bit 0 flipped: data passes through, syndrome 100
    req_data = {7'h54, 7'h00};
    tick();
    check_rsp("par", 1'b1, 7'h4B, 1'b1);
    check("par_cnt", 32'(err_count), CNT_EN ? 32'd2 : 32'd0);

    // Fairness: both valid, pointer currently favours requester 0
    req_valid = 2'b11; req_op = 2'b11; req_data = {7'h02, 7'h01};
    for (int i = 0; i < 4; i++) begin
      #1 check("fair_rdy", 32'(req_ready), 32'(fair_rdy[i]));
      tick();
      check_rsp("fair", fair_id[i], fair_dat[i], 1'b0);
    end

    // Backpressure: held word stays, no acceptance
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_op = 2'b01; req_data = {7'h00, 7'h0B};
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_rdy", 32'(req_ready), 32'b00);
      check("bp_dat", 32'(rsp_data), 32'h19);
      check("bp_vld", 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("drain_rdy", 32'(req_ready), 32'b01);
    tick();
    check_rsp("drain", 1'b0, 7'h55, 1'b0);
    req_valid = 2'b00;
    tick();
    check("empty_vld", 32'(rsp_valid), 32'd0);

    // Reset while FULL with both valid
    req_valid = 2'b11; req_op = 2'b11; req_data = {7'h02, 7'h0B};
    tick();
    check_rsp("pre_rst", 1'b1, 7'h19, 1'b0);
    rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_vld", 32'(rsp_valid), 32'd0);
    check("mid_rst_id",  32'(rsp_id),    32'd0);
    check("mid_rst_dat", 32'(rsp_data),  32'd0);
    check("mid_rst_cnt", 32'(err_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    #1 check("post_rst_rdy", 32'(req_ready), 32'b01);
    tick();
    check_rsp("post_rst", 1'b0, 7'h55, 1'b0);

    // Error counter: increment, clear-over-increment, saturation
    req_valid = 2'b01; req_op = 2'b00; req_data = {7'h00, 7'h51};
    tick();
    check("cnt_inc", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    err_clr = 1'b1;
    tick();
    check("cnt_clr", 32'(err_count), 32'd0);
    check("clr_err", 32'(rsp_err), 32'd1);
    err_clr = 1'b0;
    for (int i = 0; i < (1 << CNT_W) + 1; i++) tick();
    check("cnt_sat", 32'(err_count), CNT_EN ? 32'((1 << CNT_W) - 1) : 32'd0);
    req_valid = 2'b00;
    tick();
    check("final_vld", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
